// File: rtl/countdown_arbiter_if.sv
// countdown_arbiter_if
//   Bundles the requester-side signals of the shared down-counter scheduler.
//   master : requester side, drives req / req_cnt and observes the results
//   slave  : the arbiter itself
// Signals:
//   req      per-requester request level
//   req_cnt  packed load values, slice i = req_cnt[i*WIDTH +: WIDTH]
//   grant    one-hot owner of the counter
//   done     one-cycle completion pulse to the owner
//   busy     arbiter is not idle
//   count    current value of the shared down-counter
//   cur_id   index of the current owner, 0 when idle
interface countdown_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 3,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_cnt;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [WIDTH-1:0]       count;
  logic [ID_W-1:0]        cur_id;

  modport master (
    output req, req_cnt,
    input  grant, done, busy, count, cur_id
  );

  modport slave (
    input  req, req_cnt,
    output grant, done, busy, count, cur_id
  );
endinterface

// File: rtl/countdown_arbiter.sv
// countdown_arbiter
//   Shares one WIDTH-bit down-counter among N_REQ requesters. A round-robin
//   arbiter hands the counter to one requester, loads its value, counts down
//   to zero and then pulses that requester's done line for one cycle.
// Ports:
//   clk  single clock, all state changes on posedge
//   rst  synchronous active-high reset
//   bus  countdown_arbiter_if.slave (req, req_cnt in; grant, done, busy,
//        count, cur_id out, all outputs registered)
module countdown_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 3,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  countdown_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] grant_r;
  logic [N_REQ-1:0] done_r;
  logic             busy_r;
  logic [WIDTH-1:0] count_r;
  logic [ID_W-1:0]  cur_id_r;
  logic [ID_W-1:0]  winner;

  // First requester at or above p, wrapping modulo N_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [ID_W-1:0]  p);
    logic [ID_W-1:0] w;
    logic            found;
    int              idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(p) + k) % N_REQ;
      if (!found && r[idx]) begin
        w     = ID_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (int'(id) == N_REQ - 1) ? '0 : id + ID_W'(1);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    return N_REQ'(1) << id;
  endfunction

  // Decrement that stops at zero; the caller already excludes zero, this
  // keeps the counter from ever wrapping if that guard changes.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - WIDTH'(1);
  endfunction

  always_comb begin
    winner = rr_pick(bus.req, ptr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_r  <= '0;
      done_r   <= '0;
      busy_r   <= 1'b0;
      count_r  <= '0;
      cur_id_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          // count keeps its last value while idle
          if (bus.req != '0) begin
            state    <= COUNT;
            grant_r  <= onehot(winner);
            cur_id_r <= winner;
            count_r  <= bus.req_cnt[winner*WIDTH +: WIDTH];
            busy_r   <= 1'b1;
          end
        end
        COUNT: begin
          if (!bus.req[cur_id_r]) begin
            // owner withdrew: release without a done pulse, rotate past it
            state    <= IDLE;
            grant_r  <= '0;
            busy_r   <= 1'b0;
            cur_id_r <= '0;
            ptr      <= next_id(cur_id_r);
          end else if (count_r != '0) begin
            count_r <= sat_dec(count_r);
          end else begin
            state  <= DONE;
            done_r <= onehot(cur_id_r);
          end
        end
        DONE: begin
          state    <= IDLE;
          grant_r  <= '0;
          done_r   <= '0;
          busy_r   <= 1'b0;
          cur_id_r <= '0;
          ptr      <= next_id(cur_id_r);
        end
        default: begin
          state    <= IDLE;
          grant_r  <= '0;
          done_r   <= '0;
          busy_r   <= 1'b0;
          cur_id_r <= '0;
        end
      endcase
    end
  end

  assign bus.grant  = grant_r;
  assign bus.done   = done_r;
  assign bus.busy   = busy_r;
  assign bus.count  = count_r;
  assign bus.cur_id = cur_id_r;

endmodule

// File: tb/tb_countdown_arbiter.sv
// tb_countdown_arbiter
//   Self-checking bench for countdown_arbiter: a table of directed vectors,
//   hand-written multi-cycle sequences (round-robin order, abort, reset
//   mid-count, fairness) and a randomized run against a tenure-based model.
module tb_countdown_arbiter;
  localparam int N  = 4;
  localparam int W  = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  countdown_arbiter_if #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();

  countdown_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an owner with a tenure age. Age 1 is the cycle after
  // the grant; ages 1..L+1 are counting cycles, age L+2 is the done cycle.
  int m_owner = -1;
  int m_age   = 0;
  int m_L     = 0;
  int m_ptr   = 0;
  int m_count = 0;

  task automatic model_step(input logic r, input logic [N-1:0] rq,
                            input logic [N*W-1:0] rc);
    bit found;
    int idx;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_count = 0; m_age = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && rq[idx]) begin
          found   = 1;
          m_owner = idx;
          m_age   = 1;
          m_L     = int'((rc >> (idx * W)) & ((1 << W) - 1));
        end
      end
    end else if (m_age <= m_L + 1) begin
      if (!rq[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_age++;
      end
    end else begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
    if (m_owner >= 0) m_count = (m_L - (m_age - 1) > 0) ? m_L - (m_age - 1) : 0;
  endtask

  task automatic check_model(input string tag);
    int eg, ed, eb, ei;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    ed = (m_owner >= 0 && m_age == m_L + 2) ? (1 << m_owner) : 0;
    eb = (m_owner >= 0) ? 1 : 0;
    ei = (m_owner >= 0) ? m_owner : 0;
    chk({tag, "_grant"},  int'(bus.grant),  eg);
    chk({tag, "_done"},   int'(bus.done),   ed);
    chk({tag, "_busy"},   int'(bus.busy),   eb);
    chk({tag, "_count"},  int'(bus.count),  m_count);
    chk({tag, "_cur_id"}, int'(bus.cur_id), ei);
  endtask

  // Drive one cycle's inputs, let the edge happen, return at the negedge.
  task automatic cycle(input logic r, input logic [N-1:0] rq,
                       input logic [N*W-1:0] rc);
    rst         = r;
    bus.req     = rq;
    bus.req_cnt = rc;
    @(posedge clk);
    model_step(r, rq, rc);
    @(negedge clk);
  endtask

  typedef struct {
    logic           r;
    logic [N-1:0]   rq;
    logic [N*W-1:0] rc;
    logic [N-1:0]   g;
    logic [N-1:0]   d;
    logic           b;
    logic [W-1:0]   c;
    logic [IW-1:0]  id;
  } vec_t;

  function automatic vec_t mk(logic r, logic [N-1:0] rq, logic [N*W-1:0] rc,
                              logic [N-1:0] g, logic [N-1:0] d, logic b,
                              logic [W-1:0] c, logic [IW-1:0] id);
    vec_t v;
    v.r = r; v.rq = rq; v.rc = rc; v.g = g; v.d = d; v.b = b; v.c = c; v.id = id;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    logic [N-1:0] pend;
    logic [N-1:0] prevg;
    logic [N-1:0] rq;
    int gedge[$];
    int gid[$];
    int got;
    bit seen_idle;

    rst = 1'b1; bus.req = '0; bus.req_cnt = '0;

    // Expected values are the outputs after the edge that samples the row.
    vt.push_back(mk(1, 4'b1111, 12'hfff, 4'b0000, 4'b0000, 0, 0, 0)); // reset
    vt.push_back(mk(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 0, 0, 0)); // idle
    vt.push_back(mk(0, 4'b0010, 12'h018, 4'b0010, 4'b0000, 1, 3, 1)); // load 3
    vt.push_back(mk(0, 4'b0010, 12'hfff, 4'b0010, 4'b0000, 1, 2, 1)); // reload ignored
    vt.push_back(mk(0, 4'b0010, 12'hfff, 4'b0010, 4'b0000, 1, 1, 1));
    vt.push_back(mk(0, 4'b0010, 12'hfff, 4'b0010, 4'b0000, 1, 0, 1));
    vt.push_back(mk(0, 4'b0010, 12'hfff, 4'b0010, 4'b0010, 1, 0, 1)); // done pulse
    vt.push_back(mk(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 0, 0, 0)); // back to idle
    vt.push_back(mk(0, 4'b0100, 12'he3f, 4'b0100, 4'b0000, 1, 0, 2)); // load 0
    vt.push_back(mk(0, 4'b0100, 12'he3f, 4'b0100, 4'b0100, 1, 0, 2)); // done
    vt.push_back(mk(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 0, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      cycle(vt[i].r, vt[i].rq, vt[i].rc);
      chk($sformatf("vec%0d_grant", i),  int'(bus.grant),  int'(vt[i].g));
      chk($sformatf("vec%0d_done", i),   int'(bus.done),   int'(vt[i].d));
      chk($sformatf("vec%0d_busy", i),   int'(bus.busy),   int'(vt[i].b));
      chk($sformatf("vec%0d_count", i),  int'(bus.count),  int'(vt[i].c));
      chk($sformatf("vec%0d_cur_id", i), int'(bus.cur_id), int'(vt[i].id));
    end

    // All four request with L=1, each holding until its own done.
    cycle(1, '0, '0);
    pend  = 4'b1111;
    prevg = '0;
    for (int t = 1; t <= 40 && pend != '0; t++) begin
      cycle(0, pend, 12'h249);
      if (bus.grant != '0 && prevg == '0) begin
        gedge.push_back(t);
        gid.push_back(int'(bus.cur_id));
      end
      if (bus.done != '0) pend = pend & ~bus.done;
      prevg = bus.grant;
    end
    chk("rr_all_done", int'(pend), 0);
    chk("rr_ngrants", gid.size(), 4);
    for (int i = 0; i < gid.size(); i++) chk($sformatf("rr_order%0d", i), gid[i], i);
    for (int i = 1; i < gedge.size(); i++) chk($sformatf("rr_spacing%0d", i), gedge[i] - gedge[i-1], 4);
    cycle(0, 4'b1111, 12'h249);
    chk("rr_idle_gap_grant", int'(bus.grant), 0);
    cycle(0, 4'b1111, 12'h249);
    chk("rr_wrap_grant", int'(bus.grant), 1);
    chk("rr_wrap_id", int'(bus.cur_id), 0);

    // Abort: id 0 with L=7 drops its request at count 4, id 1 pending.
    cycle(1, '0, '0);
    for (int t = 0; t < 4; t++) cycle(0, 4'b0011, 12'h017);
    chk("abort_pre_grant", int'(bus.grant), 1);
    chk("abort_pre_count", int'(bus.count), 4);
    cycle(0, 4'b0010, 12'h017);
    chk("abort_grant", int'(bus.grant), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_busy", int'(bus.busy), 0);
    cycle(0, 4'b0010, 12'h017);
    chk("abort_next_grant", int'(bus.grant), 2);
    chk("abort_next_id", int'(bus.cur_id), 1);
    chk("abort_next_count", int'(bus.count), 2);

    // Reset asserted at count 2 with the request still held.
    cycle(1, '0, '0);
    for (int t = 0; t < 4; t++) cycle(0, 4'b0001, 12'h005);
    chk("rstmid_pre_count", int'(bus.count), 2);
    cycle(1, 4'b0001, 12'h005);
    chk("rstmid_grant", int'(bus.grant), 0);
    chk("rstmid_done", int'(bus.done), 0);
    chk("rstmid_busy", int'(bus.busy), 0);
    chk("rstmid_count", int'(bus.count), 0);
    chk("rstmid_cur_id", int'(bus.cur_id), 0);
    cycle(0, 4'b0001, 12'h005);
    chk("rstmid_regrant", int'(bus.grant), 1);
    chk("rstmid_recount", int'(bus.count), 5);

    // Fairness: id 0 holds its request forever, id 3 arrives mid-count.
    cycle(1, '0, '0);
    cycle(0, 4'b0001, 12'h002);
    chk("fair_first", int'(bus.grant), 1);
    got = -1;
    seen_idle = 0;
    for (int t = 0; t < 20 && got < 0; t++) begin
      cycle(0, 4'b1001, 12'h002);
      if (bus.grant == '0) seen_idle = 1;
      else if (seen_idle) got = int'(bus.cur_id);
    end
    chk("fair_next_owner", got, 3);

    // Randomized traffic against the model.
    cycle(1, '0, '0);
    rq = '0;
    for (int t = 0; t < 800; t++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      cycle(($urandom_range(0, 99) == 0), rq, N*W'($urandom));
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
